div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit restoring divider that serves the execute stage's div/divu requests.
- The execute stage raises start, holds operands steady and stalls the pipeline; div_unit iterates one quotient bit per clock.
- It then returns {remainder, quotient} with a ready flag and holds it until start is withdrawn.
- Sits beside the execute stage; the result is written to HI (remainder) / LO (quotient).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- signed_div_i  in  1  1 = signed (div), 0 = unsigned (divu); sampled at start acceptance.
- opdata1_i  in  WIDTH  dividend; sampled at start acceptance.
- opdata2_i  in  WIDTH  divisor; sampled at start acceptance.
- start_i  in  1  request; held high by requester until it has consumed the result.
- annul_i  in  1  cancel in-flight division (flush/exception).
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- All state and outputs are registered. Reset (rst=0, async) forces: state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor=0. Reset mid-division abandons it with no output.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i==0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON, with cnt=0.
  - Latch magnitudes: if signed_div_i and the operand MSB=1, take the two's complement, else raw value. Latch signed_div_i, both sign bits, and the raw operands.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END with quotient=0, remainder=0.
- ON:
  - If annul_i=1 -> FREE immediately (ready_o stays 0).
  - Else, while cnt<WIDTH, do one restoring step: shift the partial remainder/dividend left by 1 and trial-subtract the divisor.
    - Non-negative difference: keep the difference, quotient bit=1.
    - Otherwise: keep the partial remainder, quotient bit=0.
    - cnt+1.
  - At cnt==WIDTH, apply sign fixup and go -> END:
    - Quotient negated if signed and the operand signs differ.
    - Remainder negated if signed and the dividend is negative.
- END:
  - result_o <= {rem, quot}, ready_o <= 1.
  - While start_i=1, stay in END and hold outputs.
  - When start_i=0 -> FREE, and next edge ready_o=0, result_o=0.
- Latency from the accepting edge E0: edges E1..E32 perform the steps, E33 does fixup and enters END, ready_o is high after E34.
  - Divide-by-zero: ready_o is high after E2.
- annul_i in BYZERO/END/FREE: no effect (only ON is cancellable). annul_i together with start_i in FREE: the request is not accepted.
- Arithmetic is modulo 2^WIDTH:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (no trap).
  - Divisor magnitude 0x80000000 handled without overflow (33-bit trial subtract).
- Operand changes after acceptance are ignored. A new request is accepted only in FREE, so there is at least one FREE cycle between back-to-back divisions.

Test Plan:
- Unsigned divide: divu 100/7 (start held) -> ready_o rises after the 34th edge; result_o={0x00000002, 0x0000000E}. Drop start_i -> next edge ready_o=0, result_o=0.
- Signed divide, negative dividend: div -7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}.
- Signed divide, negative divisor: div 7/-2 -> result_o={0x00000001, 0xFFFFFFFD}.
- Divide by zero: opdata2_i=0 -> ready_o high after the 2nd edge; result_o=0.
- Signed overflow: div 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Unsigned large divisor: divu 0xFFFFFFFF/0x80000000 -> {0x7FFFFFFF, 0x00000001}.
- Annul mid-division: annul_i=1 on the 10th ON cycle -> FREE next edge, ready_o never asserts. A new divu 9/3 started next cycle -> {0, 3} after 34 edges.
- Async reset: assert rst=0 between clock edges during ON -> outputs 0 immediately, no ready. Release and issue divu 1/1 -> {0, 1}.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per clock,
// returns {remainder, quotient} with ready_o held until start_i is withdrawn.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             sign1_reg;
    logic             sign2_reg;

    logic             accept;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step;

    assign accept = start_i && !annul_i;
    assign mag1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Trial subtract is done at WIDTH+1 bits so a divisor magnitude of 2^(W-1) cannot overflow.
    assign shifted  = {rem_reg, quot_reg[WIDTH-1]};
    assign trial_ok = shifted >= {1'b0, divisor_reg};
    assign rem_step = trial_ok ? WIDTH'(shifted - {1'b0, divisor_reg}) : shifted[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FREE:    if (accept) state_next = (opdata2_i == '0) ? BYZERO : ON;
            BYZERO:  state_next = END;
            ON: begin
                if (annul_i)
                    state_next = FREE;
                else if (cnt_reg == CW'(WIDTH))
                    state_next = END;
            end
            END:     if (!start_i) state_next = FREE;
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= FREE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            result_o    <= '0;
            ready_o     <= 1'b0;
        end else begin
            case (state_reg)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        cnt_reg     <= '0;
                        rem_reg     <= '0;
                        quot_reg    <= mag1;
                        divisor_reg <= mag2;
                        sign1_reg   <= signed_div_i && opdata1_i[WIDTH-1];
                        sign2_reg   <= signed_div_i && opdata2_i[WIDTH-1];
                    end
                end
                BYZERO: begin
                    rem_reg  <= '0;
                    quot_reg <= '0;
                end
                ON: begin
                    if (!annul_i) begin
                        if (cnt_reg < CW'(WIDTH)) begin
                            rem_reg  <= rem_step;
                            quot_reg <= {quot_reg[WIDTH-2:0], trial_ok};
                            cnt_reg  <= cnt_reg + 1'b1;
                        end else begin
                            // Sign bits were latched already qualified by signed_div_i.
                            if (sign1_reg ^ sign2_reg) quot_reg <= -quot_reg;
                            if (sign1_reg)             rem_reg  <= -rem_reg;
                        end
                    end
                end
                END: begin
                    if (start_i) begin
                        result_o <= {rem_reg, quot_reg};
                        ready_o  <= 1'b1;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus randomized divisions
// checked against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        longint sa, sb, lq, lr;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
    endtask

    // First posedge is the accepting edge; operands are scrambled right after it.
    task automatic wait_ready(input int lat, input logic [63:0] exp);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
        n = 0;
        seen = 0;
        while (!seen && n < 45) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) seen = 1;
        end
        check("latency", 64'(n), 64'(lat));
        check("result", result_o, exp);
        $display("div lat=%0d result=%h expected=%h", n, result_o, exp);
    endtask

    // annul_i in END must not disturb the held result.
    task automatic release_result(input logic [63:0] exp);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("hold_ready", 64'(ready_o), 64'd1);
        check("hold_result", result_o, exp);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        issue(sgn, a, b);
        wait_ready((b == 32'd0) ? 2 : 34, exp);
        release_result(exp);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        bit          rdy_seen;

        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E});
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
        run_div(1'b0, 32'd1234, 32'd0, 64'd0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
        run_div(1'b0, 32'hFFFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'h00000001});

        // start with annul in FREE must not be accepted until annul drops
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd4;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        wait_ready(34, {32'd0, 32'd5});
        release_result({32'd0, 32'd5});

        // annul on the 10th ON cycle, then an immediate new request
        issue(1'b0, 32'd5000, 32'd7);
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        wait_ready(34, {32'd0, 32'd3});
        release_result({32'd0, 32'd3});

        // async reset during ON, then divu 1/1
        issue(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) rdy_seen = 1;
        end
        check("rst_on_no_ready", 64'(rdy_seen), 64'd0);
        opdata1_i = 32'd1; opdata2_i = 32'd1; signed_div_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_ready(34, {32'd0, 32'd1});

        // async reset while the result is held clears outputs immediately
        #3;
        rst = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2, 3:    b = $urandom_range(1, 20);
                4:       b = -($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_div(sgn, a, b, ref_div(sgn, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
